// File: rtl/cmd_status_ctrl.sv
// Per-channel command launch / status tracking with sticky done/err flags and a masked interrupt.
// Optional per-channel watchdog enabled by defining CMD_WDOG_EN.
module cmd_status_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int TMO_CYC = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_wr_i,
  input  logic [NUM_CH-1:0] cmd_data_i,
  input  logic [NUM_CH-1:0] irq_clr_i,
  input  logic [NUM_CH-1:0] irq_en_i,
  output logic [NUM_CH-1:0] start_o,
  input  logic [NUM_CH-1:0] ready_i,
  output logic [NUM_CH-1:0] status_axi_o,
  output logic [NUM_CH-1:0] done_o,
  output logic [NUM_CH-1:0] err_o,
  output logic              irq_o
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t state;
    logic   start, busy, done, err;
    logic   req, tmo, set_done, set_err;

    assign req = cmd_wr_i & cmd_data_i[gi];

`ifdef CMD_WDOG_EN
    logic [19:0] cnt;

    // Timeout fires on the edge that would bring the count to TMO_CYC.
    assign tmo = (state != IDLE) && (cnt == 20'(TMO_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (state == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
`else
    assign tmo = 1'b0;
`endif

    assign set_err  = ((state != IDLE) && req) || tmo;
    assign set_done = (state == RUN) && ready_i[gi] && !tmo;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        start <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b0;
        err   <= 1'b0;
      end else begin
        // A new set on the same edge overrides the write-1-to-clear.
        done <= set_done | (done & ~irq_clr_i[gi]);
        err  <= set_err  | (err  & ~irq_clr_i[gi]);
        case (state)
          IDLE: begin
            if (req) begin
              state <= LAUNCH;
              start <= 1'b1;
              busy  <= 1'b1;
            end
          end
          LAUNCH: begin
            if (tmo) begin
              state <= IDLE;
              start <= 1'b0;
              busy  <= 1'b0;
            end else if (!ready_i[gi]) begin
              state <= RUN;
              start <= 1'b0;
            end
          end
          RUN: begin
            if (tmo || ready_i[gi]) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            start <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end

    assign start_o[gi]      = start;
    assign status_axi_o[gi] = busy;
    assign done_o[gi]       = done;
    assign err_o[gi]        = err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |((done_o | err_o) & irq_en_i);
    end
  end

endmodule

// File: doc/cmd_status_ctrl.md
CMD_STATUS_CTRL -- requirements
Module: cmd_status_ctrl

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4: number of independent engine channels, range 1..16.
REQ-002 SHALL provide parameter TMO_CYC, default 65535: watchdog limit in clk cycles, range 1..2^20-1.
REQ-003 SHALL provide port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port cmd_wr_i  input  1  AXI command-register write strobe, one cycle per write.
REQ-006 SHALL provide port cmd_data_i  input  NUM_CH  write data; bit c=1 requests a start on channel c.
REQ-007 SHALL provide port irq_clr_i  input  NUM_CH  write-1-to-clear strobe for done and err bits, per channel.
REQ-008 SHALL provide port irq_en_i  input  NUM_CH  interrupt mask, level, per channel.
REQ-009 SHALL provide port start_o  output  NUM_CH  start request to engine c.
REQ-010 SHALL provide port ready_i  input  NUM_CH  engine c idle flag: high = idle, low = working.
REQ-011 SHALL provide port status_axi_o  output  NUM_CH  busy flag per channel.
REQ-012 SHALL provide port done_o  output  NUM_CH  sticky completion flag per channel.
REQ-013 SHALL provide port err_o  output  NUM_CH  sticky error flag per channel.
REQ-014 SHALL provide port irq_o  output  1  OR of (done_o | err_o) & irq_en_i, registered.

Function
REQ-015 SHALL run one FSM per channel with states IDLE, LAUNCH and RUN, all channels independent.
REQ-016 IDLE: cmd_wr_i=1 with cmd_data_i[c]=1 SHALL move the channel to LAUNCH at the next edge; start_o[c] and status_axi_o[c] rise in that same cycle (latency 1).
REQ-017 LAUNCH: start_o[c] SHALL stay high until ready_i[c] is sampled low; the channel then moves to RUN and start_o[c] falls.
REQ-018 RUN: ready_i[c] sampled high SHALL move the channel to IDLE, clear status_axi_o[c] and set done_o[c] in the same edge.
REQ-019 A start request for a channel in LAUNCH or RUN SHALL be ignored and SHALL set err_o[c]; FSM state is unaffected.
REQ-020 irq_clr_i[c]=1 SHALL clear done_o[c] and err_o[c] at the next edge; on a same-cycle set, the set SHALL win.
REQ-021 A start request and irq_clr_i[c] in the same cycle SHALL both take effect; done_o[c] and err_o[c] clear, and the channel launches.
REQ-022 irq_o SHALL update one cycle after any change in done_o, err_o or irq_en_i.
REQ-023 start_o, status_axi_o, done_o, err_o and irq_o SHALL be driven directly from flops, with no combinational path from any input.
REQ-024 In IDLE, changes on ready_i[c] SHALL be ignored.

Reset
REQ-025 Assertion of reset SHALL immediately force all FSMs to IDLE and all outputs to 0, asynchronously and at any point in operation.
REQ-026 Deassertion SHALL take effect on the next clk edge; a start request in that edge SHALL be honoured.
REQ-027 A channel reset mid-LAUNCH or mid-RUN SHALL NOT set done_o or err_o.

Configuration
REQ-028 Macro CMD_WDOG_EN defined: each channel SHALL have a cycle counter that clears on entry to LAUNCH and increments in LAUNCH and RUN.
REQ-029 With CMD_WDOG_EN defined, when the counter reaches TMO_CYC the channel SHALL go to IDLE, drop start_o[c] and status_axi_o[c], and set err_o[c], not done_o[c].
REQ-030 Macro CMD_WDOG_EN undefined: there SHALL be no counter logic, and LAUNCH and RUN SHALL wait indefinitely.

Verification
REQ-031 Test start and complete: NUM_CH=4, write 0b0001, engine drops ready 3 cycles later and raises it 10 cycles after that -> start_o[0] high for 4 cycles, status_axi_o[0] high for 14 cycles, then done_o[0]=1 and irq_o=1 one cycle later with irq_en_i=0b0001.
REQ-032 Test busy collision: during RUN on ch2, write 0b0100 -> err_o[2]=1, FSM continues, done_o[2] sets on completion.
REQ-033 Test set-wins clear: irq_clr_i[1]=1 in the same cycle that RUN completes on ch1 -> done_o[1]=1 afterwards.
REQ-034 Test watchdog: CMD_WDOG_EN with TMO_CYC=8, ready_i[3] held high -> after 8 cycles in LAUNCH, start_o[3]=0, err_o[3]=1, done_o[3]=0.
REQ-035 Test mid-run reset: assert reset during RUN on all channels, then write 0b1111 -> all outputs 0 immediately, all four start_o high 1 cycle after the write.
REQ-036 Test masking: done_o=0b0011 with irq_en_i=0b1100 -> irq_o=0; set irq_en_i=0b0001 -> irq_o=1 next cycle.
